// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: initialises an HD44780-compatible 16x2 panel in 8-bit mode,
// then endlessly copies the 32-entry character RAM onto the glass, one frame
// being a line-0 address command, 16 characters, a line-1 address command and
// 16 more characters.
module lcd_refresh_ctrl #(
  parameter int POWERUP_CYCLES    = 20,
  parameter int E_PULSE_CYCLES    = 4,
  parameter int CMD_WAIT_CYCLES   = 8,
  parameter int CLEAR_WAIT_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  output logic [4:0] lcdPosRead,
  input  logic [7:0] dataRead,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_on,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_A   = (POWERUP_CYCLES > E_PULSE_CYCLES) ? POWERUP_CYCLES : E_PULSE_CYCLES;
  localparam int MAX_B   = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, LINE_CMD, FETCH, FETCH_WAIT, SEND} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic [4:0]       pos_q, pos_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic             init_done_q, init_done_d;
  logic             frame_done_q, frame_done_d;
  logic             lcd_on_q;
  logic             byte_done;
  logic             sending_d;
  int               wait_cycles;

  // Power-on command list: 8-bit/2-line, display on, entry increment, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // The line is implied by the next position: pos 0..15 on line 0, 16..31 on line 1.
  function automatic logic [7:0] line_cmd(input logic [4:0] pos);
    return pos[4] ? 8'hC0 : 8'h80;
  endfunction

  // Clear Display needs the long settle time; everything else the short one.
  assign wait_cycles = (!rs_q && data_q == 8'h01) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;

  // State register and registered pin drivers; lcd_e is a flop so it cannot glitch.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= PWR_WAIT;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      init_idx_q   <= '0;
      pos_q        <= '0;
      data_q       <= '0;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      lcd_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      pos_q        <= pos_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      e_q          <= e_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      lcd_on_q     <= 1'b1;
    end
  end

  // Next-state logic: top-level sequencing plus the per-byte SETUP/PULSE/HOLD/WAIT timer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    init_idx_d   = init_idx_q;
    pos_d        = pos_q;
    data_d       = data_q;
    rs_d         = rs_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    byte_done    = 1'b0;

    unique case (state_q)
      PWR_WAIT: begin
        if (int'(cnt_q) + 1 >= POWERUP_CYCLES) begin
          state_d    = INIT;
          phase_d    = PH_SETUP;
          cnt_d      = '0;
          init_idx_d = 2'd0;
          data_d     = init_cmd(2'd0);
          rs_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        // RAM output is valid now: address was driven two edges ago.
        state_d = SEND;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        data_d  = dataRead;
        rs_d    = 1'b1;
      end
      default: begin
        // INIT, LINE_CMD and SEND all transmit one byte through the same timer.
        unique case (phase_q)
          PH_SETUP: begin
            phase_d = PH_PULSE;
            cnt_d   = '0;
          end
          PH_PULSE: begin
            if (int'(cnt_q) + 1 >= E_PULSE_CYCLES) begin
              phase_d = PH_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PH_HOLD: begin
            if (wait_cycles == 0) byte_done = 1'b1;
            else begin
              phase_d = PH_WAIT;
              cnt_d   = '0;
            end
          end
          default: begin
            if (int'(cnt_q) + 1 >= wait_cycles) byte_done = 1'b1;
            else cnt_d = cnt_q + CNT_W'(1);
          end
        endcase

        if (byte_done) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          unique case (state_q)
            INIT: begin
              rs_d = 1'b0;
              if (init_idx_q == 2'd3) begin
                init_done_d = 1'b1;
                state_d     = LINE_CMD;
                data_d      = line_cmd(pos_q);
              end else begin
                init_idx_d = init_idx_q + 2'd1;
                data_d     = init_cmd(init_idx_q + 2'd1);
              end
            end
            LINE_CMD: state_d = FETCH;
            default: begin
              // Character finished: 15 and 31 end a line, 31 also wraps to 0.
              pos_d = pos_q + 5'd1;
              if (pos_q == 5'd15 || pos_q == 5'd31) begin
                frame_done_d = (pos_q == 5'd31);
                state_d      = LINE_CMD;
                data_d       = line_cmd(pos_q + 5'd1);
                rs_d         = 1'b0;
              end else begin
                state_d = FETCH;
              end
            end
          endcase
        end
      end
    endcase

    sending_d = (state_d == INIT) || (state_d == LINE_CMD) || (state_d == SEND);
    e_d       = sending_d && (phase_d == PH_PULSE);
  end

  assign lcdPosRead = pos_q;
  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_q;
  assign lcd_on     = lcd_on_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Self-checking bench for lcd_refresh_ctrl: a behavioural RAM with random
// background writes, and a byte-schedule model that derives every byte's value
// and cycle position from the sequence index and the timing rules.
module tb_lcd_refresh_ctrl;
  localparam int PWR = 20;
  localparam int EP  = 4;
  localparam int CW  = 8;
  localparam int CLW = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] lcd_pos_read;
  logic [7:0] data_read;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_on, init_done, frame_done;

  lcd_refresh_ctrl #(
    .POWERUP_CYCLES(PWR), .E_PULSE_CYCLES(EP),
    .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .clock(clock), .reset(reset), .lcdPosRead(lcd_pos_read), .dataRead(data_read),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_on(lcd_on), .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Character RAM with registered read port.
  logic [7:0] ram [32];
  always @(posedge clock) data_read <= ram[lcd_pos_read];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Cycle n is the interval after the n-th rising edge since reset release.
  int cyc = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc = 0;
    else        cyc = cyc + 1;
  end

  // Reference model state: the byte currently expected on the bus.
  bit         mon_en = 1'b0;
  int         g;
  int         exp_setup, exp_pos, exp_frame;
  logic [7:0] exp_data;
  logic       exp_rs;
  bit         exp_is_char;
  int         fd_cycle, init_done_cycle, fd_count;
  logic [7:0] obs [4][32];

  // Byte n of the stream: 4 init commands, then frames of 34 bytes.
  task automatic load_byte(input int n);
    int k;
    g           = n;
    exp_is_char = 1'b0;
    exp_rs      = 1'b0;
    exp_pos     = 0;
    if (n < 4) begin
      exp_frame = -1;
      case (n)
        0:       exp_data = 8'h38;
        1:       exp_data = 8'h0C;
        2:       exp_data = 8'h06;
        default: exp_data = 8'h01;
      endcase
    end else begin
      exp_frame = (n - 4) / 34;
      k         = (n - 4) % 34;
      if (k == 0)       exp_data = 8'h80;
      else if (k == 17) exp_data = 8'hC0;
      else begin
        exp_is_char = 1'b1;
        exp_rs      = 1'b1;
        exp_pos     = (k < 17) ? k - 1 : k - 2;
        exp_data    = 8'h00;
      end
    end
  endtask

  task automatic model_reset();
    load_byte(0);
    exp_setup       = PWR;
    fd_cycle        = -1;
    init_done_cycle = -1;
    fd_count        = 0;
  endtask

  // Cycle-by-cycle comparison of the pins against the schedule.
  always @(negedge clock) begin
    int hold, w, nxt;
    if (mon_en) begin
      hold = exp_setup + EP + 1;
      check("lcd_rw", lcd_rw, 0);
      check("lcd_on", lcd_on, 1);
      check("lcd_e", lcd_e, (cyc > exp_setup && cyc <= exp_setup + EP));
      check("init_done", init_done, (init_done_cycle >= 0 && cyc >= init_done_cycle));
      check("frame_done", frame_done, (cyc == fd_cycle));
      if (frame_done) fd_count++;
      if (exp_is_char && (cyc == exp_setup - 2 || cyc == exp_setup - 1))
        check("pos_read", lcd_pos_read, exp_pos);
      if (exp_is_char && cyc == exp_setup - 2) exp_data = ram[exp_pos];
      if (cyc >= exp_setup && cyc <= hold) begin
        check("lcd_data", lcd_data, exp_data);
        check("lcd_rs", lcd_rs, exp_rs);
      end
      if (cyc == hold) begin
        if (exp_is_char && exp_frame < 4) obs[exp_frame][exp_pos] = lcd_data;
        w   = (!exp_rs && exp_data == 8'h01) ? CLW : CW;
        nxt = hold + 1 + w;
        if (g == 3) init_done_cycle = nxt;
        if (exp_is_char && exp_pos == 31) fd_cycle = nxt;
        load_byte(g + 1);
        exp_setup = nxt + (exp_is_char ? 2 : 0);
      end
    end
  end

  // Random background writes from frame 1 on, avoiding the positions with directed checks.
  initial begin
    int a;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en && exp_frame >= 1 && $urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 31);
        if (!(a inside {0, 3, 5, 15, 16, 31})) ram[a] = 8'($urandom);
      end
    end
  end

  task automatic write_ram(input int a, input logic [7:0] d);
    @(posedge clock);
    #1;
    ram[a] = d;
  endtask

  task automatic wait_model(input string tag, input int fr, input int p, input int budget);
    int  n;
    bit  ok;
    n = 0;
    while (!(exp_frame == fr && exp_is_char && exp_pos >= p) && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (exp_frame == fr && exp_is_char && exp_pos >= p);
    check(tag, ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_e"}, lcd_e, 0);
    check({tag, "_rs"}, lcd_rs, 0);
    check({tag, "_rw"}, lcd_rw, 0);
    check({tag, "_data"}, lcd_data, 0);
    check({tag, "_pos"}, lcd_pos_read, 0);
    check({tag, "_on"}, lcd_on, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
    ram[0]  = 8'h48;
    ram[15] = 8'h5A;
    ram[16] = 8'h41;
    ram[31] = 8'h21;
    ram[3]  = 8'h33;
    ram[5]  = 8'h10;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 32; i++) obs[f][i] = 8'h00;

    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("rst0");
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Frame 1: pos5 rewritten before its fetch, pos3 after its fetch.
    wait_model("reach_f1_p1", 1, 1, 3000);
    write_ram(5, 8'h37);
    wait_model("reach_f1_p8", 1, 8, 3000);
    write_ram(3, 8'h55);

    // Frame 2: abort a character strobe with reset.
    wait_model("reach_f2_p10", 2, 10, 3000);
    n = 0;
    while (!(exp_is_char && cyc == exp_setup + 2) && n < 200) begin
      @(negedge clock);
      n++;
    end
    #2;
    check("e_before_reset", lcd_e, 1);
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs("rst_mid");

    check("frame_done_count", fd_count, 2);
    check("f0_pos0", obs[0][0], 8'h48);
    check("f0_pos15", obs[0][15], 8'h5A);
    check("f0_pos16", obs[0][16], 8'h41);
    check("f0_pos31", obs[0][31], 8'h21);
    check("f1_pos5_live", obs[1][5], 8'h37);
    check("f1_pos3_old", obs[1][3], 8'h33);
    check("f2_pos3_new", obs[2][3], 8'h55);

    // Full init must repeat from the power-up wait after release.
    repeat (2) @(negedge clock);
    model_reset();
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;
    wait_model("reinit_f0_p20", 0, 20, 3000);
    check("reinit_pos0", obs[0][0], 8'h48);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
- Single-clock controller that owns the read port of the 32-entry LCD character RAM.
- Initialises an HD44780-compatible 16x2 character display in 8-bit mode.
- Then continuously refreshes the panel: reads positions 0..31 and drives each byte onto the LCD bus with correct E-strobe timing.
- Sits between the LCD character RAM and the board LCD pins. The processor writes characters to the RAM; this block keeps the glass in sync with the RAM.

Parameters:
- POWERUP_CYCLES, 20, idle cycles after reset release before the first command.
- E_PULSE_CYCLES, 4, cycles lcd_e is held high per byte (minimum 1).
- CMD_WAIT_CYCLES, 8, post-byte wait for every byte except Clear Display.
- CLEAR_WAIT_CYCLES, 32, post-byte wait after Clear Display (0x01, rs=0).

Ports:
- clock  input  1  system clock. The same clock also drives the RAM read_clock.
- reset  input  1  asynchronous, active-low reset.
- lcdPosRead  output  5  LCD RAM read address.
- dataRead  input  8  LCD RAM read data, registered by the RAM (1-cycle latency).
- lcd_data  output  8  LCD data bus.
- lcd_rs  output  1  0=command, 1=character.
- lcd_rw  output  1  tied 0 (write only).
- lcd_e  output  1  enable strobe.
- lcd_on  output  1  panel power/backlight enable, 1 from reset release.
- init_done  output  1  high once the init sequence completes; stays high until reset.
- frame_done  output  1  one-cycle pulse after character 31 of each frame completes its wait.

Behaviour:
- Reset asserted (reset=0), immediate regardless of state:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcdPosRead=0, lcd_on=0, init_done=0, frame_done=0.
  - FSM goes to PWR_WAIT and all counters clear.
  - An in-flight E pulse is aborted; lcd_e goes low asynchronously.
- Top FSM states: PWR_WAIT, INIT, LINE_CMD, FETCH, FETCH_WAIT, SEND.
- PWR_WAIT: count POWERUP_CYCLES cycles, then enter INIT.
- INIT: send commands in order 0x38, 0x0C, 0x06, 0x01 (rs=0). After 0x01 completes, init_done=1 and go to LINE_CMD with line=0.
- LINE_CMD: send 0x80 (line 0) or 0xC0 (line 1) with rs=0, then go to FETCH.
- FETCH: drive lcdPosRead=pos for 1 cycle, then go to FETCH_WAIT.
- FETCH_WAIT: hold lcdPosRead for 1 cycle, then latch dataRead into the output byte. Data is captured 2 clock edges after the address is first driven.
- Character send: each latched character is sent with rs=1.
- After a character send:
  - pos 15: go to LINE_CMD with line=1.
  - pos 31: pulse frame_done, set pos=0, line=0, go to LINE_CMD.
  - otherwise: pos+1, go to FETCH.
- pos is a 5-bit counter and wraps 31->0 naturally.
- SEND sub-sequence, per byte:
  - SETUP: 1 cycle, lcd_data/lcd_rs valid, lcd_e=0.
  - PULSE: E_PULSE_CYCLES cycles, lcd_e=1.
  - HOLD: 1 cycle, lcd_e=0, data unchanged.
  - WAIT: CMD_WAIT_CYCLES cycles, or CLEAR_WAIT_CYCLES if the byte was 0x01 with rs=0.
  - lcd_data and lcd_rs stay stable from SETUP through HOLD. lcd_e never rises outside PULSE.
- Byte timing: a command byte occupies 2+E_PULSE+WAIT cycles. A character byte adds 2 fetch cycles.
- Frame length: 34 bytes (2 line commands + 32 characters).
- RAM updates by other writers during a frame are picked up on the next fetch of that position. No tearing protection is provided.
- Counters are sized by $clog2 of the largest parameter+1. A parameter value of 0 for either wait count means no WAIT cycles.

Test Plan:
- Reset/init: default params, release reset and monitor lcd_e falling edges. Required: no strobe for 20 cycles, then rs=0 bytes 0x38, 0x0C, 0x06, 0x01 in order, init_done rises after the 0x01 wait, lcd_on=1 throughout.
- Clear timing: measure the gap from the 0x01 HOLD to the next SETUP. Required: exactly 32 cycles. Every other command gap must be 8 cycles.
- Data path: RAM model preloaded with pos0=0x48, pos15=0x5A, pos16=0x41, pos31=0x21. Required sequence: 0x80(rs=0), 0x48(rs=1) … 0x5A(rs=1), 0xC0(rs=0), 0x41(rs=1) … 0x21(rs=1). lcdPosRead matches each position 2 cycles before the data is latched.
- Frame wrap: run 2 frames. Required: frame_done pulses for exactly 1 cycle after pos31's wait, the next byte is 0x80 (rs=0), and lcdPosRead returns to 0.
- Live update: write pos5=0x37 into the RAM model mid-frame before pos5 is fetched. Required: 0x37 appears in the same frame. A write after the fetch appears only in the next frame.
- Reset mid-operation: assert reset while lcd_e=1 during a character pulse. Required: lcd_e=0 in the same cycle, all outputs at reset values, and after release the full init sequence repeats from PWR_WAIT.
